// File: rtl/frame_buffer_writer_if.sv
// Pixel-in and memory-out buses of the frame buffer writer.
//
// Both buses are valid/ready handshakes. A transfer happens on a rising clk edge
// where the producer's valid and the consumer's ready are both high. The producer
// may raise valid at any time and never waits for ready before doing so. The
// consumer may drive ready from its own registered state only.
//   pixel bus : valid = frame_rd_en, ready = frame_ready (producer = rasterizer)
//   memory bus: valid = mem_req,     ready = mem_ack     (producer = this block)
// While mem_req is high and mem_ack is low, mem_addr and mem_wdata stay stable.
interface frame_buffer_writer_if #(
    parameter int ADDR_W = 20
);
    logic              frame_rd_en;
    logic [9:0]        frame_x;
    logic [9:0]        frame_y;
    logic [2:0]        px_color;
    logic              frame_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_wdata;
    logic              mem_ack;

    // View of the writer block itself
    modport slave (
        input  frame_rd_en, frame_x, frame_y, px_color, mem_ack,
        output frame_ready, mem_req, mem_addr, mem_wdata
    );

    // View of the surrounding system (rasterizer plus memory)
    modport master (
        output frame_rd_en, frame_x, frame_y, px_color, mem_ack,
        input  frame_ready, mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/frame_buffer_writer.sv
// Frame buffer writer: buffers rasterizer pixel writes in a small FIFO, turns each
// one into a linear address in the draw half of a double-buffered frame store, and
// swaps the draw and display halves on vsync once a finished frame has drained.
module frame_buffer_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_buffer_writer_if.slave  bus,
    input  logic                  raster_done,
    input  logic                  vsync,
    output logic                  disp_buf_sel,
    output logic                  swap_done,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ACTIVE     = 2'd0,
        DRAIN      = 2'd1,
        WAIT_VSYNC = 2'd2
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = ADDR_W - 1;
    localparam int EW = 23;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [9:0]  X_LIM    = 10'(H_RES);
    localparam logic [9:0]  Y_LIM    = 10'(V_RES);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_raster_prev;
    logic              r_draw_buf;
    logic              r_swap_done;
    logic              w_swap;
    logic              w_raster_rise;

    logic [EW-1:0]     r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_accept;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_head;
    logic [9:0]        w_head_x;
    logic [9:0]        w_head_y;
    logic [2:0]        w_head_c;
    logic [IW-1:0]     w_idx;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_mem_wdata;

    // Handshake, range filter and FIFO occupancy decode
    always_comb begin
        w_full        = (r_count == FULL_CNT);
        w_empty       = (r_count == '0);
        w_ready       = (r_state == ACTIVE) && !w_full;
        w_accept      = bus.frame_rd_en && w_ready;
        w_in_range    = (bus.frame_x < X_LIM) && (bus.frame_y < Y_LIM);
        w_push        = w_accept && w_in_range;
        w_pop         = (!r_mem_req || bus.mem_ack) && !w_empty;
        w_head        = r_fifo[r_rd_ptr];
        w_head_y      = w_head[22:13];
        w_head_x      = w_head[12:3];
        w_head_c      = w_head[2:0];
        w_idx         = IW'(w_head_y) * IW'(H_RES) + IW'(w_head_x);
        w_raster_rise = raster_done && !r_raster_prev;
    end

    // FIFO storage; emptiness is tracked by the pointers, so no reset is needed here
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {bus.frame_y, bus.frame_x, bus.px_color};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Memory output register: reload from FIFO head whenever the slot is free or completing
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_pop) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= {r_draw_buf, w_idx};
            r_mem_wdata <= w_head_c;
        end else if (bus.mem_ack) begin
            r_mem_req   <= 1'b0;
        end
    end

    // State register, raster_done edge history, buffer select and swap pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ACTIVE;
            r_raster_prev <= 1'b0;
            r_draw_buf    <= 1'b1;
            r_swap_done   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_raster_prev <= raster_done;
            r_swap_done   <= w_swap;
            if (w_swap) r_draw_buf <= ~r_draw_buf;
        end
    end

    // Next-state decode; vsync only counts once the drain has finished
    always_comb begin
        w_next_state = r_state;
        w_swap       = 1'b0;
        case (r_state)
            ACTIVE: begin
                if (w_raster_rise) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (w_empty && !r_mem_req) w_next_state = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (vsync) begin
                    w_swap       = 1'b1;
                    w_next_state = ACTIVE;
                end
            end
            default: w_next_state = ACTIVE;
        endcase
    end

    assign bus.frame_ready = w_ready;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign disp_buf_sel    = ~r_draw_buf;
    assign swap_done       = r_swap_done;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: directed pixel writes, expected memory writes
// queued at accept time and checked by an independent memory-port monitor.
module tb_frame_buffer_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raster_done = 1'b0;
  logic       vsync = 1'b0;
  logic       disp_buf_sel;
  logic       swap_done;
  logic [1:0] dbg_state;

  frame_buffer_writer_if #(.ADDR_W(20)) bus();

  frame_buffer_writer #(
    .FIFO_DEPTH(8), .H_RES(640), .V_RES(480), .ADDR_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .raster_done(raster_done),
    .vsync(vsync),
    .disp_buf_sel(disp_buf_sel),
    .swap_done(swap_done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [22:0] exp_q[$];
  logic        exp_buf = 1'b1;
  int          wr_cnt = 0;
  int          req_cycles = 0;
  int          swap_cnt = 0;
  logic [19:0] last_addr = '0;
  logic [2:0]  last_data = '0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [22:0] prev_bus = '0;
  logic [22:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: sample the memory port on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_req) req_cycles++;
      if (swap_done) swap_cnt++;
      if (prev_req && !prev_ack)
        chk("hold_stable", {8'd0, bus.mem_req, bus.mem_addr, bus.mem_wdata}, {8'd0, 1'b1, prev_bus});
      if (bus.mem_req && bus.mem_ack) begin
        wr_cnt++;
        last_addr = bus.mem_addr;
        last_data = bus.mem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=0x%0h expected=none", {bus.mem_addr, bus.mem_wdata});
        end else begin
          mon_exp = exp_q.pop_front();
          chk("write", {9'd0, bus.mem_addr, bus.mem_wdata}, {9'd0, mon_exp});
        end
      end
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
      prev_bus = {bus.mem_addr, bus.mem_wdata};
    end else begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end
  end

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    bus.frame_rd_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_cycle(input logic en, input logic [9:0] x, input logic [9:0] y,
                             input logic [2:0] c, output logic acc);
    logic [18:0] idx;
    bus.frame_rd_en = en;
    bus.frame_x     = x;
    bus.frame_y     = y;
    bus.px_color    = c;
    acc = en && bus.frame_ready;
    @(posedge clk);
    #1;
    bus.frame_rd_en = 1'b0;
    if (acc && x < 10'd640 && y < 10'd480) begin
      idx = 19'(int'(y) * 640 + int'(x));
      exp_q.push_back({exp_buf, idx, c});
    end
  endtask

  task automatic send_px(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      drive_cycle(1'b1, x, y, c, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.mem_req) && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending%0d expected=0", exp_q.size());
    end
  endtask

  task automatic wait_state(input logic [1:0] s);
    int n;
    n = 0;
    while (dbg_state != s && n < 200) begin
      idle(1);
      n++;
    end
    chk("wait_state", {30'd0, dbg_state}, {30'd0, s});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    int          r0;
    int          acc_n;
    logic        acc;
    bus.frame_rd_en = 1'b0;
    bus.frame_x     = '0;
    bus.frame_y     = '0;
    bus.px_color    = '0;
    bus.mem_ack     = 1'b0;

    // 1: reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    chk("rst_frame_ready", {31'd0, bus.frame_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", {12'd0, bus.mem_addr}, 32'd0);
    chk("rst_disp_buf_sel", {31'd0, disp_buf_sel}, 32'd0);
    chk("rst_swap_done", {31'd0, swap_done}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // 2: single write, ack held high
    bus.mem_ack = 1'b1;
    r0 = req_cycles;
    w0 = wr_cnt;
    send_px(10'd5, 10'd2, 3'd3);
    wait_drain();
    chk("single_req_cycles", req_cycles - r0, 32'd1);
    chk("single_wr_cnt", wr_cnt - w0, 32'd1);
    chk("single_addr", {12'd0, last_addr}, 32'h0008_0505);
    chk("single_data", {29'd0, last_data}, 32'd3);

    // 3: backpressure fill, then drain in order
    bus.mem_ack = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 10'(i), 10'd10, 3'(i), acc);
      if (acc) acc_n++;
    end
    chk("fill_accepted", acc_n, 32'd9);
    chk("fill_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    chk("fill_pending", exp_q.size(), 32'd9);
    w0 = wr_cnt;
    bus.mem_ack = 1'b1;
    wait_drain();
    chk("fill_wr_cnt", wr_cnt - w0, 32'd9);

    // 4: range filter
    w0 = wr_cnt;
    send_px(10'd640, 10'd0, 3'd1);
    send_px(10'd0, 10'd480, 3'd2);
    send_px(10'd639, 10'd479, 3'd5);
    wait_drain();
    chk("range_wr_cnt", wr_cnt - w0, 32'd1);
    chk("range_addr", {12'd0, last_addr}, 32'h000C_AFFF);
    chk("range_data", {29'd0, last_data}, 32'd5);

    // 5: drain then swap; vsync during drain is ignored
    bus.mem_ack = 1'b0;
    send_px(10'd1, 10'd0, 3'd1);
    send_px(10'd2, 10'd0, 3'd2);
    send_px(10'd3, 10'd0, 3'd4);
    raster_done = 1'b1;
    idle(1);
    chk("drain_state", {30'd0, dbg_state}, 32'd1);
    chk("drain_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    vsync = 1'b1;
    idle(1);
    vsync = 1'b0;
    idle(2);
    chk("drain_vsync_ignored", swap_cnt, 32'd0);
    chk("drain_still", {30'd0, dbg_state}, 32'd1);
    bus.mem_ack = 1'b1;
    wait_state(2'd2);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("wait_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    vsync = 1'b1;
    idle(1);
    vsync = 1'b0;
    exp_buf = 1'b0;
    chk("swap_pulse", {31'd0, swap_done}, 32'd1);
    chk("swap_disp_sel", {31'd0, disp_buf_sel}, 32'd1);
    chk("swap_state", {30'd0, dbg_state}, 32'd0);
    idle(1);
    chk("swap_pulse_end", {31'd0, swap_done}, 32'd0);
    idle(3);
    chk("swap_count", swap_cnt, 32'd1);
    chk("no_retrigger", {30'd0, dbg_state}, 32'd0);
    raster_done = 1'b0;
    send_px(10'd1, 10'd1, 3'd1);
    wait_drain();
    chk("newbuf_addr", {12'd0, last_addr}, 32'd641);

    // 6: reset mid-transfer drops everything pending
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) send_px(10'(i + 100), 10'd7, 3'(i));
    idle(1);
    chk("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    exp_buf = 1'b1;
    idle(1);
    chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.frame_ready}, 32'd1);
    chk("mid_rst_disp_sel", {31'd0, disp_buf_sel}, 32'd0);
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    w0 = wr_cnt;
    idle(10);
    chk("no_stale_writes", wr_cnt - w0, 32'd0);
    send_px(10'd3, 10'd0, 3'd7);
    wait_drain();
    chk("post_rst_addr", {12'd0, last_addr}, 32'h0008_0003);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
